// File: rtl/jtoutrun_obj_romrsp_pkg.sv
// jtoutrun_obj_romrsp_pkg: shared types for the object ROM responder
package jtoutrun_obj_romrsp_pkg;
  localparam int OBJ_AW = 18;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_WAIT_LO,
    ST_REQ_HI,
    ST_WAIT_HI
  } state_t;
endpackage

// File: rtl/jtoutrun_obj_romrsp_if.sv
// jtoutrun_obj_romrsp_if: object fetch port plus SDRAM slot signals of the responder
interface jtoutrun_obj_romrsp_if #(parameter int AW = 22);
  logic          obj_cs;
  logic [17:0]   obj_addr;
  logic [31:0]   obj_data;
  logic          obj_ok;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          sdram_dst;
  logic [15:0]   sdram_din;
  logic [7:0]    st_fetch;
  modport master (
    output obj_cs, obj_addr, sdram_ack, sdram_dst, sdram_din,
    input  obj_data, obj_ok, sdram_req, sdram_addr, st_fetch
  );
  modport slave (
    input  obj_cs, obj_addr, sdram_ack, sdram_dst, sdram_din,
    output obj_data, obj_ok, sdram_req, sdram_addr, st_fetch
  );
endinterface

// File: rtl/jtoutrun_obj_romrsp.sv
// jtoutrun_obj_romrsp: splits 32-bit object ROM fetches into two SDRAM word reads behind a one-entry cache
module jtoutrun_obj_romrsp
  import jtoutrun_obj_romrsp_pkg::*;
#(
  parameter int          AW     = 22,
  parameter logic [AW-1:0] OFFSET = '0
) (
  input logic clk,
  input logic rst,
  jtoutrun_obj_romrsp_if.slave bus
);
  state_t            r_st;
  logic [OBJ_AW-1:0] r_tag;
  logic              r_valid;
  logic [31:0]       r_data;
  logic              r_req;
  logic [AW-1:0]     r_addr;
  logic [7:0]        r_fetch;
  logic              w_hit;
  logic [AW-1:0]     w_base;
  assign w_hit          = r_valid & (r_tag == bus.obj_addr);
  assign w_base         = OFFSET + AW'({bus.obj_addr, 1'b0});
  assign bus.obj_ok     = bus.obj_cs & w_hit;
  assign bus.obj_data   = r_data;
  assign bus.sdram_req  = r_req;
  assign bus.sdram_addr = r_addr;
  assign bus.st_fetch   = r_fetch;
  // A started fetch always runs to completion so the SDRAM slot never sees an abandoned read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= ST_IDLE;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_fetch <= '0;
    end else begin
      case (r_st)
        ST_IDLE: if (bus.obj_cs && !w_hit) begin
          r_tag   <= bus.obj_addr;
          r_valid <= 1'b0;
          r_req   <= 1'b1;
          r_addr  <= w_base;
          r_st    <= ST_REQ_LO;
        end
        ST_REQ_LO: if (bus.sdram_ack) begin
          r_req <= bus.sdram_dst;
          if (bus.sdram_dst) begin
            r_data[15:0] <= bus.sdram_din;
            r_addr       <= r_addr + 1'b1;
          end
          r_st <= bus.sdram_dst ? ST_REQ_HI : ST_WAIT_LO;
        end
        ST_WAIT_LO: if (bus.sdram_dst) begin
          r_data[15:0] <= bus.sdram_din;
          r_req        <= 1'b1;
          r_addr       <= r_addr + 1'b1;
          r_st         <= ST_REQ_HI;
        end
        ST_REQ_HI: if (bus.sdram_ack) begin
          r_req <= 1'b0;
          if (bus.sdram_dst) begin
            r_data[31:16] <= bus.sdram_din;
            r_valid       <= 1'b1;
            r_fetch       <= r_fetch + 1'b1;
          end
          r_st <= bus.sdram_dst ? ST_IDLE : ST_WAIT_HI;
        end
        ST_WAIT_HI: if (bus.sdram_dst) begin
          r_data[31:16] <= bus.sdram_din;
          r_valid       <= 1'b1;
          r_fetch       <= r_fetch + 1'b1;
          r_st          <= ST_IDLE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
endmodule
